// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: architectural constants and small PC helpers.
package riscv_pkg;

    localparam int unsigned XLEN             = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] pcPlus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; used for in-flight PCs and buffered responses.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           push,
    input  logic [WIDTH-1:0]               pushData,
    input  logic                           pop,
    output logic [WIDTH-1:0]               popData,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr;
    logic             doPush, doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign doPop   = pop & ~empty;
    // A push into a full FIFO is allowed only when a pop frees the slot in the same cycle.
    assign doPush  = push & (~full | doPop);
    assign popData = mem[rdPtr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !clear) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/fetch_stage.sv
// Pipelined instruction fetch: PC generation, bounded outstanding requests,
// redirect squashing via a drop counter, and the IF/ID register.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          StallF,
    input  logic          StallD,
    input  logic          FlushD,
    input  logic          PCSrcE,
    input  logic [31:0]   PCTargetE,
    fetch_stage_if.master imem,
    output logic [31:0]   InstrD,
    output logic [31:0]   PCD,
    output logic [31:0]   PCPlus4D,
    output logic          ValidD
);
    localparam int unsigned      CNT_W   = $clog2(FQ_DEPTH + 1);
    localparam logic [CNT_W:0]   MAX_OCC = (CNT_W + 1)'(FQ_DEPTH);

    logic [31:0]      PCF, heldAddr;
    logic             reqPending, reqStale;
    logic [CNT_W-1:0] dropCnt;
    logic             grant, staleGrant, keep, dropping, loadReal, bypass;
    logic [CNT_W:0]   occupancy, inFlightLeft;

    logic             ifEmpty, ifFull;
    logic [CNT_W-1:0] ifCount;
    logic [31:0]      ifHead;
    logic             rsPush, rsPop, rsEmpty, rsFull;
    logic [CNT_W-1:0] rsCount;
    logic [63:0]      rsHead;

    logic [31:0]      nextInstr, nextPC;
    logic             nextValid;

    assign occupancy  = {1'b0, ifCount} + {1'b0, rsCount};
    assign imem.req   = reset & (reqPending | ((occupancy < MAX_OCC) & ~StallF));
    assign imem.addr  = reqPending ? heldAddr : PCF;
    assign grant      = imem.req & imem.gnt;
    // A request redirected away while waiting for gnt still completes; its response is junk.
    assign staleGrant = grant & reqPending & reqStale;

    assign dropping   = imem.rvalid & (dropCnt != '0);
    assign keep       = imem.rvalid & (dropCnt == '0) & ~PCSrcE;
    assign loadReal   = ~StallD & ~FlushD & ~PCSrcE;
    assign rsPop      = loadReal & ~rsEmpty;
    // Empty buffer: a fresh response goes straight into IF/ID for rvalid+1 latency.
    assign bypass     = loadReal & rsEmpty & keep;
    assign rsPush     = keep & ~bypass;

    assign inFlightLeft = {1'b0, ifCount} + (CNT_W + 1)'(grant) - (CNT_W + 1)'(imem.rvalid);

    fetch_fifo #(.WIDTH(32), .DEPTH(FQ_DEPTH)) inflightQ (
        .clk      (clk),
        .reset    (reset),
        .clear    (1'b0),
        .push     (grant),
        .pushData (imem.addr),
        .pop      (imem.rvalid),
        .popData  (ifHead),
        .full     (ifFull),
        .empty    (ifEmpty),
        .count    (ifCount)
    );

    fetch_fifo #(.WIDTH(64), .DEPTH(FQ_DEPTH)) respFifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (PCSrcE),
        .push     (rsPush),
        .pushData ({imem.rdata, ifHead}),
        .pop      (rsPop),
        .popData  (rsHead),
        .full     (rsFull),
        .empty    (rsEmpty),
        .count    (rsCount)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PCF        <= RESET_PC;
            heldAddr   <= RESET_PC;
            reqPending <= 1'b0;
            reqStale   <= 1'b0;
            dropCnt    <= '0;
        end else begin
            if (PCSrcE)                              PCF <= PCTargetE;
            else if (grant && !(reqPending && reqStale)) PCF <= pcPlus4(imem.addr);
            if (imem.req && !reqPending) heldAddr <= imem.addr;
            reqPending <= imem.req & ~imem.gnt;
            reqStale   <= imem.req & ~imem.gnt & (reqStale | PCSrcE);
            if (PCSrcE) dropCnt <= inFlightLeft[CNT_W-1:0];
            else        dropCnt <= dropCnt + CNT_W'(staleGrant) - CNT_W'(dropping);
        end
    end

    always_comb begin
        nextInstr = NOP_INSTR;
        nextPC    = PCD;
        nextValid = 1'b0;
        if (rsPop) begin
            nextInstr = rsHead[63:32];
            nextPC    = rsHead[31:0];
            nextValid = 1'b1;
        end else if (bypass) begin
            nextInstr = imem.rdata;
            nextPC    = ifHead;
            nextValid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            InstrD   <= NOP_INSTR;
            PCD      <= RESET_PC;
            PCPlus4D <= pcPlus4(RESET_PC);
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            InstrD   <= nextInstr;
            PCD      <= nextPC;
            PCPlus4D <= pcPlus4(nextPC);
            ValidD   <= nextValid;
        end
    end

`ifndef SYNTHESIS
    respNoOverflow: assert property (@(posedge clk) disable iff (!reset)
        !(keep && rsFull && !rsPop))
        else $error("fetch_stage: response arrived with response buffer full");
    queueConsistent: assert property (@(posedge clk) disable iff (!reset)
        !(imem.rvalid && ifEmpty) && !(grant && ifFull && !imem.rvalid))
        else $error("fetch_stage: in-flight queue under/overflow");
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order instruction memory model.
module tb_fetch_stage;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        StallF, StallD, FlushD, PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;
    logic        gntEn, rvalidEn;

    int compared   = 0;
    int mismatched = 0;

    fetch_stage_if imemBus ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .imem      (imemBus),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    // Memory: grants follow gntEn; responses in order, at least one cycle after gnt.
    logic [31:0] pendAddr [8];
    logic [2:0]  mwr, mrd;
    logic        mrvalid;
    logic [31:0] mrdata;
    int          grantCnt;
    logic [31:0] lastGrantAddr;
    logic        memGrant;

    assign imemBus.gnt    = gntEn;
    assign imemBus.rvalid = mrvalid;
    assign imemBus.rdata  = mrdata;
    assign memGrant       = imemBus.req & imemBus.gnt;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mwr <= 3'd0; mrd <= 3'd0; mrvalid <= 1'b0; mrdata <= 32'd0;
            grantCnt <= 0; lastGrantAddr <= 32'd0;
        end else begin
            mrvalid <= 1'b0;
            if (memGrant) begin
                pendAddr[mwr] <= imemBus.addr;
                mwr           <= mwr + 3'd1;
                grantCnt      <= grantCnt + 1;
                lastGrantAddr <= imemBus.addr;
            end
            if (rvalidEn) begin
                if (mrd != mwr) begin
                    mrvalid <= 1'b1; mrdata <= memWord(pendAddr[mrd]); mrd <= mrd + 3'd1;
                end else if (memGrant) begin
                    mrvalid <= 1'b1; mrdata <= memWord(imemBus.addr); mrd <= mrd + 3'd1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'd0; gntEn = 1'b1; rvalidEn = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'd0; gntEn = 1'b1; rvalidEn = 1'b1;
        #1;
        compared++;
        if ({imemBus.req, ValidD, InstrD} !== {1'b0, 1'b0, 32'h0000_0013}) begin
            mismatched++;
            $display("FAIL reset_ctrl: req/valid/instr got %b/%b/%h want 0/0/00000013",
                     imemBus.req, ValidD, InstrD);
        end
        compared++;
        if ({PCD, PCPlus4D, imemBus.addr} !== {32'h0, 32'h4, 32'h0}) begin
            mismatched++;
            $display("FAIL reset_pc: PCD/PCPlus4D/addr got %h/%h/%h want 0/4/0",
                     PCD, PCPlus4D, imemBus.addr);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        compared++;
        if ({imemBus.req, imemBus.addr} !== {1'b1, 32'h0}) begin
            mismatched++;
            $display("FAIL first_req: req/addr got %b/%h want 1/00000000",
                     imemBus.req, imemBus.addr);
        end
        repeat (3) @(negedge clk);
        compared++;
        if ({ValidD, PCD} !== {1'b1, 32'h4}) begin
            mismatched++;
            $display("FAIL pre_midreset: ValidD/PCD got %b/%h want 1/00000004", ValidD, PCD);
        end
        #2 reset = 1'b0;
        #1;
        compared++;
        if ({ValidD, PCD, PCPlus4D, imemBus.req} !== {1'b0, 32'h0, 32'h4, 1'b0}) begin
            mismatched++;
            $display("FAIL async_midreset: ValidD/PCD/PCPlus4D/req got %b/%h/%h/%b want 0/0/4/0",
                     ValidD, PCD, PCPlus4D, imemBus.req);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        do_reset();
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        @(negedge clk);
        compared++;
        if (ValidD !== 1'b0) begin
            mismatched++;
            $display("FAIL stream_fill: ValidD got %b want 0", ValidD);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if ({ValidD, PCD, PCPlus4D, InstrD} !==
                {1'b1, pcs[i], pcs[i] + 32'd4, memWord(pcs[i])}) begin
                mismatched++;
                $display("FAIL stream_%0d: ValidD/PCD/PCPlus4D/InstrD got %b/%h/%h/%h want 1/%h/%h/%h",
                         i, ValidD, PCD, PCPlus4D, InstrD, pcs[i], pcs[i] + 32'd4, memWord(pcs[i]));
            end
        end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        @(negedge clk);
        gntEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            StallF = (i % 2 == 1);
            if (i == 3) gntEn = 1'b1;
            #1;
            compared++;
            if ({imemBus.req, imemBus.addr} !== {1'b1, 32'h4}) begin
                mismatched++;
                $display("FAIL gnt_hold_%0d: req/addr got %b/%h want 1/00000004",
                         i, imemBus.req, imemBus.addr);
            end
        end
        @(negedge clk);
        compared++;
        if ({grantCnt, lastGrantAddr, imemBus.req} !== {32'd2, 32'h4, 1'b0}) begin
            mismatched++;
            $display("FAIL gnt_once: grants/lastAddr/req got %0d/%h/%b want 2/00000004/0",
                     grantCnt, lastGrantAddr, imemBus.req);
        end
        StallF = 1'b0;
        #1;
        compared++;
        if ({imemBus.req, imemBus.addr} !== {1'b1, 32'h8}) begin
            mismatched++;
            $display("FAIL gnt_next: req/addr got %b/%h want 1/00000008",
                     imemBus.req, imemBus.addr);
        end
        @(negedge clk);
        compared++;
        if ({ValidD, PCD, InstrD} !== {1'b1, 32'h4, memWord(32'h4)}) begin
            mismatched++;
            $display("FAIL gnt_resp: ValidD/PCD/InstrD got %b/%h/%h want 1/00000004/%h",
                     ValidD, PCD, InstrD, memWord(32'h4));
        end
    endtask

    task automatic test_redirect();
        int waited;
        do_reset();
        rvalidEn = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (imemBus.req !== 1'b0) begin
            mismatched++;
            $display("FAIL redir_full: req got %b want 0 (two in flight)", imemBus.req);
        end
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0100;
        @(negedge clk);
        PCSrcE = 1'b0; rvalidEn = 1'b1;
        waited = 0;
        while (ValidD !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        compared++;
        if ({ValidD, PCD, InstrD} !== {1'b1, 32'h100, memWord(32'h100)}) begin
            mismatched++;
            $display("FAIL redir_target: ValidD/PCD/InstrD got %b/%h/%h want 1/00000100/%h",
                     ValidD, PCD, InstrD, memWord(32'h100));
        end
    endtask

    task automatic test_stall_decode();
        do_reset();
        repeat (2) @(negedge clk);
        StallD = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if ({ValidD, PCD, InstrD, imemBus.req} !== {1'b1, 32'h0, memWord(32'h0), 1'b0}) begin
                mismatched++;
                $display("FAIL stalld_hold_%0d: ValidD/PCD/InstrD/req got %b/%h/%h/%b want 1/0/%h/0",
                         i, ValidD, PCD, InstrD, imemBus.req, memWord(32'h0));
            end
        end
        StallD = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            compared++;
            if ({ValidD, PCD, InstrD} !== {1'b1, 32'(4 * i), memWord(32'(4 * i))}) begin
                mismatched++;
                $display("FAIL stalld_resume_%0d: ValidD/PCD/InstrD got %b/%h/%h want 1/%h/%h",
                         i, ValidD, PCD, InstrD, 32'(4 * i), memWord(32'(4 * i)));
            end
        end
    endtask

    task automatic test_flush();
        do_reset();
        repeat (2) @(negedge clk);
        FlushD = 1'b1;
        @(negedge clk);
        FlushD = 1'b0;
        compared++;
        if ({ValidD, InstrD, PCD} !== {1'b0, 32'h0000_0013, 32'h0}) begin
            mismatched++;
            $display("FAIL flush_bubble: ValidD/InstrD/PCD got %b/%h/%h want 0/00000013/0",
                     ValidD, InstrD, PCD);
        end
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            compared++;
            if ({ValidD, PCD} !== {1'b1, 32'(4 * i)}) begin
                mismatched++;
                $display("FAIL flush_next_%0d: ValidD/PCD got %b/%h want 1/%h",
                         i, ValidD, PCD, 32'(4 * i));
            end
        end
    endtask

    task automatic test_wrap();
        int waited;
        do_reset();
        repeat (2) @(negedge clk);
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
        @(negedge clk);
        PCSrcE = 1'b0;
        compared++;
        if (ValidD !== 1'b0) begin
            mismatched++;
            $display("FAIL wrap_bubble: ValidD got %b want 0", ValidD);
        end
        waited = 0;
        while (ValidD !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        compared++;
        if ({ValidD, PCD, PCPlus4D, InstrD} !==
            {1'b1, 32'hFFFF_FFFC, 32'h0, memWord(32'hFFFF_FFFC)}) begin
            mismatched++;
            $display("FAIL wrap_last: ValidD/PCD/PCPlus4D/InstrD got %b/%h/%h/%h want 1/fffffffc/0/%h",
                     ValidD, PCD, PCPlus4D, InstrD, memWord(32'hFFFF_FFFC));
        end
        @(negedge clk);
        compared++;
        if ({ValidD, PCD, PCPlus4D} !== {1'b1, 32'h0, 32'h4}) begin
            mismatched++;
            $display("FAIL wrap_zero: ValidD/PCD/PCPlus4D got %b/%h/%h want 1/0/4",
                     ValidD, PCD, PCPlus4D);
        end
    endtask

    initial begin
        reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        PCSrcE = 1'b0; PCTargetE = 32'd0; gntEn = 1'b0; rvalidEn = 1'b0;
        test_reset();
        test_stream();
        test_gnt_stall();
        test_redirect();
        test_stall_decode();
        test_flush();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
